// File: rtl/chacha_xor_stream.sv
// Purpose: XORs a plaintext beat stream with buffered keystream blocks (stream-cipher data path).
// Latency: 1 cycle from accepted input beat to registered ciphertext beat.
// Backpressure: in_ready drops when no keystream is buffered or the output register is stalled.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ks_valid/ks_ready/ks_block       keystream block load (byte 0 in LSBs)
//   in_valid/in_ready/in_data/keep/last   plaintext beats (lane 0 in LSBs)
//   out_valid/out_ready/out_data/keep/last ciphertext beats
//   msg_bytes                        byte count of the most recently completed message
//   err                              sticky keep-mask protocol error
module chacha_xor_stream #(
    parameter int DATA_SIZE   = 8,
    parameter int LANES       = 16,
    parameter int BLOCK_BYTES = 64,
    parameter int BUF_BLOCKS  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ks_valid,
    output logic                              ks_ready,
    input  logic [BLOCK_BYTES*DATA_SIZE-1:0]  ks_block,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*DATA_SIZE-1:0]        in_data,
    input  logic [LANES-1:0]                  in_keep,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*DATA_SIZE-1:0]        out_data,
    output logic [LANES-1:0]                  out_keep,
    output logic                              out_last,
    output logic [31:0]                       msg_bytes,
    output logic                              err
);
    localparam int BEAT_W = LANES * DATA_SIZE;
    localparam int BEATS  = BLOCK_BYTES / LANES;
    localparam int BP_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (BUF_BLOCKS > 1) ? $clog2(BUF_BLOCKS) : 1;
    localparam int FILL_W = $clog2(BUF_BLOCKS + 1);

    localparam logic [BP_W-1:0]   BP_LAST  = BP_W'(BEATS - 1);
    localparam logic [BP_W-1:0]   BP_ONE   = BP_W'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(BUF_BLOCKS - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(BUF_BLOCKS);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
    localparam logic [LANES-1:0]  KEEP_ONE = LANES'(1);

    // Each stored block is viewed as BEATS slices of one beat width, so the
    // beat pointer indexes the keystream slice directly.
    logic [BEATS-1:0][BEAT_W-1:0] ks_mem [BUF_BLOCKS];

    logic [FILL_W-1:0] fill;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [BP_W-1:0]   bp;
    logic [31:0]       byte_cnt;

    logic              ks_load;
    logic              beat_acc;
    logic              blk_free;
    logic [BEAT_W-1:0] ks_beat;
    logic [BEAT_W-1:0] xor_dat;
    logic [31:0]       keep_cnt;
    logic [31:0]       cnt_sum;
    logic              keep_contig;
    logic              keep_bad;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign ks_ready = (fill < FILL_MAX);
    assign in_ready = (fill != '0) && (!out_valid || out_ready);
    assign ks_load  = ks_valid && ks_ready;
    assign beat_acc = in_valid && in_ready;
    // Any last beat releases the block: the next message must start on fresh keystream.
    assign blk_free = beat_acc && ((bp == BP_LAST) || in_last);

    always_comb begin
        ks_beat  = ks_mem[rd_ptr][bp];
        xor_dat  = '0;
        keep_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_keep[i]) begin
                xor_dat[i*DATA_SIZE +: DATA_SIZE] =
                    in_data[i*DATA_SIZE +: DATA_SIZE] ^ ks_beat[i*DATA_SIZE +: DATA_SIZE];
            end
            keep_cnt = keep_cnt + 32'(in_keep[i]);
        end
    end

    assign cnt_sum = byte_cnt + keep_cnt;

    // A legal mask is 2^k-1 with k>=1: adding one clears every set bit
    // (all-ones wraps to zero, which is also legal).
    assign keep_contig = (in_keep != '0) && ((in_keep & (in_keep + KEEP_ONE)) == '0);
    assign keep_bad    = !keep_contig || (!(&in_keep) && !in_last);

    // Keystream storage carries no reset; fill = 0 marks it empty.
    always_ff @(posedge clk) begin
        if (ks_load) begin
            ks_mem[wr_ptr] <= ks_block;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            bp        <= '0;
            byte_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            msg_bytes <= '0;
            err       <= 1'b0;
        end else begin
            if (ks_load) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (blk_free) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({ks_load, blk_free})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase

            if (beat_acc) begin
                out_valid <= 1'b1;
                out_data  <= xor_dat;
                out_keep  <= in_keep;
                out_last  <= in_last;
                bp        <= blk_free ? '0 : bp + BP_ONE;
                if (in_last) begin
                    msg_bytes <= cnt_sum;
                    byte_cnt  <= '0;
                end else begin
                    byte_cnt  <= cnt_sum;
                end
                if (keep_bad) begin
                    err <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_chacha_xor_stream.sv
// Bench for chacha_xor_stream: directed scenarios plus randomized traffic,
// checked by a byte-level reference model feeding a scoreboard queue.
module tb_chacha_xor_stream;
    localparam int LANES       = 16;
    localparam int BLOCK_BYTES = 64;
    localparam int BUF_BLOCKS  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ks_valid;
    logic         ks_ready;
    logic [511:0] ks_block;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_keep;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [15:0]  out_keep;
    logic         out_last;
    logic [31:0]  msg_bytes;
    logic         err;

    chacha_xor_stream #(
        .DATA_SIZE(8), .LANES(LANES), .BLOCK_BYTES(BLOCK_BYTES), .BUF_BLOCKS(BUF_BLOCKS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_block(ks_block),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .msg_bytes(msg_bytes), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic [31:0]  m;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] ks_q[$];
    int           off;
    logic [31:0]  cnt;
    logic         err_exp;
    bit           ks_fire;
    bit           in_fire;
    int           tests;
    int           fails;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [127:0] rnd_beat();
        logic [127:0] b;
        for (int i = 0; i < 4; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Reference model: keystream is a queue of 64-byte blocks consumed byte by byte.
    task automatic model_beat();
        exp_t         e;
        logic [511:0] blk;
        int           n;
        bit           seen0;
        bit           bad;
        e     = '0;
        n     = 0;
        seen0 = 0;
        bad   = 0;
        blk   = ks_q[0];
        for (int i = 0; i < LANES; i++) begin
            if (in_keep[i]) begin
                e.d[8*i +: 8] = in_data[8*i +: 8] ^ blk[8*(off+i) +: 8];
                n++;
                if (seen0) bad = 1;
            end else begin
                seen0 = 1;
            end
        end
        if (n == 0 || (n < LANES && !in_last)) bad = 1;
        if (bad) err_exp = 1'b1;
        cnt = cnt + 32'(n);
        e.k = in_keep;
        e.l = in_last;
        off = off + LANES;
        if (in_last || off == BLOCK_BYTES) begin
            blk = ks_q.pop_front();
            off = 0;
        end
        if (in_last) begin
            e.m = cnt;
            cnt = '0;
        end
        exp_q.push_back(e);
    endtask

    // Input-side sampler: handshake flags, control checks and model update.
    always @(negedge clk) begin
        ks_fire = 0;
        in_fire = 0;
        if (rst_n) begin
            check("err", err, err_exp);
            check("ks_ready", ks_ready, ks_q.size() < BUF_BLOCKS);
            check("in_ready", in_ready, (ks_q.size() > 0) && (!out_valid || out_ready));
            ks_fire = ks_valid && ks_ready;
            in_fire = in_valid && in_ready;
            if (in_fire) begin
                if (ks_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL accept_without_ks: in_ready=1 required 0");
                end else begin
                    model_beat();
                end
            end
            if (ks_fire) ks_q.push_back(ks_block);
        end
    end

    // Output monitor: compares the presented beat with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: out_valid=1 with nothing expected, data %h", out_data);
            end else begin
                e = exp_q[0];
                check("out_data", out_data, e.d);
                check("out_keep", out_keep, e.k);
                check("out_last", out_last, e.l);
                if (e.l) check("msg_bytes", msg_bytes, e.m);
                if (out_ready) e = exp_q.pop_front();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ks(input logic [511:0] b);
        int t = 0;
        ks_valid = 1'b1;
        ks_block = b;
        do begin
            cyc();
            t++;
        end while (!ks_fire && t < 200);
        tests++;
        if (!ks_fire) begin
            fails++;
            $display("FAIL ks_timeout: ks block not taken in %0d cycles", t);
        end
        ks_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        do begin
            cyc();
            t++;
        end while (!in_fire && t < 200);
        tests++;
        if (!in_fire) begin
            fails++;
            $display("FAIL beat_timeout: beat not taken in %0d cycles", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ks_ready"}, ks_ready, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_keep"}, out_keep, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_msg_bytes"}, msg_bytes, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        ks_q.delete();
        off     = 0;
        cnt     = '0;
        err_exp = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] b;
        int left;
        int n;
        int c;
        tests = 0;
        fails = 0;
        model_clear();
        rst_n     = 1'b0;
        ks_valid  = 1'b0;
        ks_block  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) cyc();
        reset_checks("rst0");
        rst_n = 1'b1;

        // No keystream: beats must be held off.
        in_valid = 1'b1;
        in_data  = '1;
        in_keep  = '1;
        in_last  = 1'b0;
        repeat (5) begin
            cyc();
            check("noks_in_ready", in_ready, 0);
            check("noks_out_valid", out_valid, 0);
        end
        for (int j = 0; j < 64; j++) b[8*j +: 8] = 8'(j);
        send_ks(b);
        check("first_beat_ready", in_ready, 1);
        for (int j = 0; j < 4; j++) send_beat('1, 16'hFFFF, j == 3);
        repeat (3) cyc();
        check("blk_msg_bytes", msg_bytes, 64);
        check("blk_fill_empty", in_ready, 0);

        // 20-byte message, then a message that must start on the next block.
        send_ks(rnd_blk());
        send_ks(rnd_blk());
        send_beat(rnd_beat(), 16'hFFFF, 1'b0);
        send_beat(rnd_beat(), 16'h000F, 1'b1);
        repeat (3) cyc();
        check("short_msg_bytes", msg_bytes, 20);
        send_beat(rnd_beat(), 16'hFFFF, 1'b1);
        repeat (3) cyc();
        check("next_msg_bytes", msg_bytes, 16);

        // Randomized traffic with output stalls and a busy keystream source.
        left = 0;
        c    = 0;
        while ((c < 3000 || left != 0 || (in_valid && !in_fire)) && c < 8000) begin
            if (!ks_valid || ks_fire) begin
                ks_valid = ($urandom % 3) != 0;
                ks_block = rnd_blk();
            end
            if (!in_valid || in_fire) begin
                if (left == 0 && c >= 3000) begin
                    in_valid = 1'b0;
                end else if (($urandom % 4) == 0) begin
                    in_valid = 1'b0;
                end else begin
                    if (left == 0) left = $urandom_range(1, 100);
                    n        = (left > 16) ? 16 : left;
                    in_keep  = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
                    in_data  = rnd_beat();
                    in_last  = (left == n);
                    left     = left - n;
                    in_valid = 1'b1;
                end
            end
            out_ready = ($urandom % 4) != 0;
            cyc();
            c++;
        end
        in_valid  = 1'b0;
        ks_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        check("drain_empty", exp_q.size(), 0);

        // Illegal keep mask sets the sticky error.
        if (ks_q.size() == 0) send_ks(rnd_blk());
        send_beat(rnd_beat(), 16'h00F0, 1'b1);
        repeat (2) cyc();
        check("err_set", err, 1);
        repeat (3) cyc();
        check("err_sticky", err, 1);

        // Reset with a beat in flight.
        if (ks_q.size() == 0) send_ks(rnd_blk());
        send_beat(rnd_beat(), 16'hFFFF, 1'b0);
        rst_n = 1'b0;
        model_clear();
        #1;
        reset_checks("rst1");
        cyc();
        rst_n = 1'b1;
        send_ks(rnd_blk());
        send_beat(rnd_beat(), 16'hFFFF, 1'b1);
        repeat (3) cyc();
        check("post_rst_msg_bytes", msg_bytes, 16);
        check("post_rst_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
